// File: rtl/mem_wr_buffer_if.sv
// Core-side store port, forwarding lookup and external data-memory bus of the store write buffer.
// The buffer binds to the slave modport; whatever drives stores and the bus binds to master.
interface mem_wr_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    logic                     i_wr_valid;
    logic [AW-1:0]            i_wr_addr;
    logic [DW-1:0]            i_wr_data;
    logic                     o_wr_ready;
    logic [AW-1:0]            i_rd_addr;
    logic                     o_fwd_hit;
    logic [DW-1:0]            o_fwd_data;
    logic                     o_bus_valid;
    logic [AW-1:0]            o_bus_addr;
    logic [DW-1:0]            o_bus_data;
    logic                     i_bus_ack;
    logic [$clog2(DEPTH):0]   o_count;
    logic                     o_timeout;

    modport slave (
        input  i_wr_valid, i_wr_addr, i_wr_data, i_rd_addr, i_bus_ack,
        output o_wr_ready, o_fwd_hit, o_fwd_data, o_bus_valid, o_bus_addr, o_bus_data,
        output o_count, o_timeout
    );

    modport master (
        output i_wr_valid, i_wr_addr, i_wr_data, i_rd_addr, i_bus_ack,
        input  o_wr_ready, o_fwd_hit, o_fwd_data, o_bus_valid, o_bus_addr, o_bus_data,
        input  o_count, o_timeout
    );
endinterface

// File: rtl/mem_wr_buffer.sv
// Store write buffer: in-order FIFO of stores drained over a valid/ack bus, with
// store-to-load forwarding from occupied entries and a sticky bus-ack timeout flag.
module mem_wr_buffer #(
    parameter int DEPTH   = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    mem_wr_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [AW-1:0] mem_addr_q [DEPTH];
    logic [DW-1:0] mem_data_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [0:0]    state_q, state_d;
    logic          bus_valid_q, bus_valid_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [DW-1:0] bus_data_q, bus_data_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_q, timeout_d;

    logic wr_ready;
    logic push;
    logic pop;

    // Readiness depends only on registered occupancy, so the ack never reaches the core.
    assign wr_ready = (count_q != CW'(DEPTH));
    assign push     = bus.i_wr_valid && wr_ready;

    always_comb begin
        state_d     = state_q;
        bus_valid_d = bus_valid_q;
        bus_addr_d  = bus_addr_q;
        bus_data_d  = bus_data_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d     = ST_BUSY;
                    bus_valid_d = 1'b1;
                    bus_addr_d  = mem_addr_q[rd_ptr_q];
                    bus_data_d  = mem_data_q[rd_ptr_q];
                    wait_cnt_d  = '0;
                end
            end
            ST_BUSY: begin
                if (bus.i_bus_ack) begin
                    pop         = 1'b1;
                    bus_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    if (wait_cnt_q != {TW{1'b1}}) begin
                        wait_cnt_d = wait_cnt_q + TW'(1);
                    end
                    if ((TIMEOUT != 0) && (wait_cnt_d == TW'(TIMEOUT))) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + (push ? PW'(1) : PW'(0));
        rd_ptr_d = rd_ptr_q + (pop  ? PW'(1) : PW'(0));
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_IDLE;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            bus_valid_q <= bus_valid_d;
            bus_addr_q  <= bus_addr_d;
            bus_data_q  <= bus_data_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    // Entry storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= bus.i_wr_addr;
            mem_data_q[wr_ptr_q] <= bus.i_wr_data;
        end
    end

    // Slot gi holds the gi-th oldest live entry; a later (younger) match overrides an older one.
    logic [PW-1:0]    age_idx [DEPTH];
    logic [DEPTH-1:0] age_match;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
        assign age_idx[gi]   = rd_ptr_q + PW'(gi);
        assign age_match[gi] = (CW'(gi) < count_q) &&
                               (mem_addr_q[age_idx[gi]] == bus.i_rd_addr);
    end

    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_match[i]) begin
                fwd_hit  = 1'b1;
                fwd_data = mem_data_q[age_idx[i]];
            end
        end
    end

    assign bus.o_wr_ready  = wr_ready;
    assign bus.o_fwd_hit   = fwd_hit;
    assign bus.o_fwd_data  = fwd_data;
    assign bus.o_bus_valid = bus_valid_q;
    assign bus.o_bus_addr  = bus_addr_q;
    assign bus.o_bus_data  = bus_data_q;
    assign bus.o_count     = count_q;
    assign bus.o_timeout   = timeout_q;
endmodule
